spmv_row_scheduler: RTL and testbench
=====================================

Name: spmv_row_scheduler

Overview:
- Sequencer for the CSR sparse matrix-vector datapath.
- Started by the synchronized single-cycle pulse from the existing falling-edge detector.
- Walks the row-pointer ROM row by row and streams each row's nonzero addresses to the value/column memories.
- Drives accumulator clear, MAC enable and per-row write-back into the result memory bank.

Parameters:
- N_ROWS, 3: number of matrix rows (result entries).
- NNZ_MAX, 9: nonzero memory depth; legal row-pointer values are 0..NNZ_MAX.
- ROW_W, $clog2(N_ROWS+1): row index / rp_addr width.
- NZ_W, $clog2(NNZ_MAX+1): nonzero address / row-pointer data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle go pulse; ignored unless IDLE.
- rp_addr  out  ROW_W  row-pointer ROM address (synchronous ROM, data valid next cycle).
- rp_data  in  NZ_W  row-pointer ROM data.
- nz_rd  out  1  nonzero memory read strobe.
- nz_addr  out  NZ_W  nonzero (value/col_idx) address.
- mac_clr  out  1  clear row accumulator.
- mac_en  out  1  accumulate; nz_rd delayed by exactly 1 cycle.
- wb_en  out  1  write accumulator into result memory entry wb_row.
- wb_row  out  ROW_W  result memory row index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky malformed-matrix flag; cleared by the next accepted start.
- perf_cycles  out  16  busy cycle count (optional feature).

Behaviour:
- Reset (async, reset=0): state IDLE, row=0; all outputs 0 (rp_addr, nz_addr, wb_row, perf_cycles = 0). Reset mid-operation aborts immediately; no partial write-back afterward.
- IDLE: start=1 -> clear err, row=0, go FETCH0.
- FETCH0: rp_addr=row; mac_clr=1 for this cycle only.
- FETCH1: rp_addr=row+1; capture lo=rp_data.
- FETCH2: capture hi=rp_data, then branch:
  - hi<lo or hi>NNZ_MAX -> err=1, go DONE (remaining rows skipped).
  - hi==lo (empty row) -> WB; writes a cleared accumulator, i.e. 0.
  - otherwise -> STREAM with nz_addr=lo.
- STREAM: nz_rd=1 each cycle, nz_addr increments by 1. When nz_addr==hi-1 -> DRAIN.
- DRAIN: nz_rd=0. mac_en is high this cycle for the last element.
- WB: wb_en=1, wb_row=row for one cycle. Then row==N_ROWS-1 -> DONE; else row+1 -> FETCH0.
- DONE: done=1 for one cycle -> IDLE.
- Cycle cost per row:
  - 3 cycles fetch.
  - k cycles stream, where k = nonzeros in the row.
  - 1 cycle drain if k>0.
  - 1 cycle write-back.
  - Plus 1 DONE cycle per run.
- mac_en is a registered copy of nz_rd. It is never high during WB, so the accumulator is stable when written.
- start while busy: ignored, no effect on sequence.
- start in the same cycle DONE exits: ignored; a new run requires start while in IDLE.
- Arithmetic: nz_addr/lo/hi unsigned NZ_W. Increment cannot wrap because hi<=NNZ_MAX is checked before STREAM.
- Outputs registered except busy (decoded from state).

Optional Feature:
- Macro SPMV_SCHED_PERF_EN.
- Defined: 16-bit counter cleared on accepted start, +1 every busy cycle including DONE, saturating at 16'hFFFF. perf_cycles shows the live count and holds its final value after DONE until the next accepted start.
- Undefined: counter not built; perf_cycles tied to 0.

Test Plan:
- Reset then rowptr=[0,2,2,5], start pulse -> nz_addr sequence 0,1 | 2,3,4. wb_en for rows 0,1,2 (row 1 empty, no nz_rd/mac_en). done 20 cycles after start-accept. err=0. perf_cycles=20 with macro.
- Check mac_en lags nz_rd by exactly 1 cycle. mac_clr pulses once per row (3 pulses). No mac_en overlaps wb_en.
- rowptr=[0,3,1,4] -> err=1 after row-1 FETCH2. wb_en only for row 0. done pulses once. Next start with valid rowptr clears err.
- rowptr=[0,0,0,0] (all empty) -> no nz_rd. Three wb_en pulses. done at cycle 13.
- start re-pulsed during STREAM, and reset=0 asserted mid-row-1 -> sequence unaffected by start. Reset forces busy=0 and wb_en=0 asynchronously, with no further activity until a new start.
- rowptr=[0,9,9,9] with NNZ_MAX=9 -> row 0 streams addresses 0..8 without wrap. rowptr containing 10 -> err=1.

Source files
------------

// File: rtl/spmv_row_scheduler_if.sv
// Datapath-side bus of the CSR row scheduler: row-pointer ROM port,
// nonzero memory read port, MAC controls and result write-back.
interface spmv_row_scheduler_if #(
  parameter int unsigned ROW_W = 2,
  parameter int unsigned NZ_W  = 4
);
  logic [ROW_W-1:0] rp_addr;
  logic [NZ_W-1:0]  rp_data;
  logic             nz_rd;
  logic [NZ_W-1:0]  nz_addr;
  logic             mac_clr;
  logic             mac_en;
  logic             wb_en;
  logic [ROW_W-1:0] wb_row;

  modport master (
    output rp_addr,
    input  rp_data,
    output nz_rd,
    output nz_addr,
    output mac_clr,
    output mac_en,
    output wb_en,
    output wb_row
  );

  modport slave (
    input  rp_addr,
    output rp_data,
    input  nz_rd,
    input  nz_addr,
    input  mac_clr,
    input  mac_en,
    input  wb_en,
    input  wb_row
  );
endinterface

// File: rtl/spmv_row_scheduler.sv
// CSR SpMV row sequencer: fetches row bounds, streams nonzero addresses,
// drives MAC clear/enable and write-back. SPMV_SCHED_PERF_EN adds a busy-cycle counter.
module spmv_row_scheduler #(
  parameter int unsigned N_ROWS  = 3,
  parameter int unsigned NNZ_MAX = 9,
  parameter int unsigned ROW_W   = $clog2(N_ROWS + 1),
  parameter int unsigned NZ_W    = $clog2(NNZ_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  spmv_row_scheduler_if.master  mem,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           perf_cycles
);

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH1, FETCH2, STREAM, DRAIN, WB, DONE
  } state_t;

  localparam logic [NZ_W-1:0]  NZ_LAST  = NZ_W'(NNZ_MAX);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

  state_t           state, state_n;
  logic [ROW_W-1:0] row, row_n;
  logic [NZ_W-1:0]  lo, lo_n;
  logic [NZ_W-1:0]  hi, hi_n;
  logic [NZ_W-1:0]  hi_m1;
  logic [NZ_W-1:0]  nz_addr, nz_addr_n;
  logic             err_n;

  logic [ROW_W-1:0] rp_addr, rp_addr_n;
  logic [ROW_W-1:0] wb_row, wb_row_n;
  logic             nz_rd, nz_rd_n;
  logic             mac_clr, mac_clr_n;
  logic             mac_en, mac_en_n;
  logic             wb_en, wb_en_n;
  logic             done_n;

  assign hi_m1 = hi - NZ_W'(1);
  assign busy  = (state != IDLE);

  assign mem.rp_addr = rp_addr;
  assign mem.nz_rd   = nz_rd;
  assign mem.nz_addr = nz_addr;
  assign mem.mac_clr = mac_clr;
  assign mem.mac_en  = mac_en;
  assign mem.wb_en   = wb_en;
  assign mem.wb_row  = wb_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row     <= '0;
      lo      <= '0;
      hi      <= '0;
      nz_addr <= '0;
      err     <= 1'b0;
      rp_addr <= '0;
      wb_row  <= '0;
      nz_rd   <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      wb_en   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      row     <= row_n;
      lo      <= lo_n;
      hi      <= hi_n;
      nz_addr <= nz_addr_n;
      err     <= err_n;
      rp_addr <= rp_addr_n;
      wb_row  <= wb_row_n;
      nz_rd   <= nz_rd_n;
      mac_clr <= mac_clr_n;
      mac_en  <= mac_en_n;
      wb_en   <= wb_en_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_n     = row;
    lo_n      = lo;
    hi_n      = hi;
    nz_addr_n = nz_addr;
    err_n     = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          err_n   = 1'b0;
          row_n   = '0;
          state_n = FETCH0;
        end
      end
      FETCH0: state_n = FETCH1;
      FETCH1: begin
        lo_n    = mem.rp_data;
        state_n = FETCH2;
      end
      // Branch on the live ROM word; hi is kept for the stream end test.
      FETCH2: begin
        hi_n = mem.rp_data;
        if ((mem.rp_data < lo) || (mem.rp_data > NZ_LAST)) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else if (mem.rp_data == lo) begin
          state_n = WB;
        end else begin
          nz_addr_n = lo;
          state_n   = STREAM;
        end
      end
      STREAM: begin
        if (nz_addr == hi_m1) state_n = DRAIN;
        else                  nz_addr_n = nz_addr + NZ_W'(1);
      end
      DRAIN: state_n = WB;
      WB: begin
        if (row == ROW_LAST) begin
          state_n = DONE;
        end else begin
          row_n   = row + ROW_W'(1);
          state_n = FETCH0;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    rp_addr_n = rp_addr;
    wb_row_n  = wb_row;
    if (state_n == FETCH0) rp_addr_n = row_n;
    if (state_n == FETCH1) rp_addr_n = row + ROW_W'(1);
    if (state_n == WB)     wb_row_n  = row;
    nz_rd_n   = (state_n == STREAM);
    mac_en_n  = nz_rd;
    mac_clr_n = (state_n == FETCH0);
    wb_en_n   = (state_n == WB);
    done_n    = (state_n == DONE);
  end

`ifdef SPMV_SCHED_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if ((state == IDLE) && start) begin
      perf_q <= '0;
    end else if ((state != IDLE) && (perf_q != '1)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_spmv_row_scheduler.sv
// Scoreboard bench for spmv_row_scheduler: a reference walk of the row-pointer
// table queues expected nonzero addresses and write-back rows per run.
module tb_spmv_row_scheduler;

  localparam int unsigned N_ROWS  = 3;
  localparam int unsigned NNZ_MAX = 9;
  localparam int unsigned ROW_W   = 2;
  localparam int unsigned NZ_W    = 4;
`ifdef SPMV_SCHED_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, err;
  logic [15:0] perf;

  spmv_row_scheduler_if #(.ROW_W(ROW_W), .NZ_W(NZ_W)) dp ();

  spmv_row_scheduler #(
    .N_ROWS (N_ROWS),
    .NNZ_MAX(NNZ_MAX)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .mem        (dp),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .perf_cycles(perf)
  );

  always #5 clk = ~clk;

  logic [NZ_W-1:0] rowptr [N_ROWS+1];
  always @(posedge clk) dp.rp_data <= rowptr[dp.rp_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int nz_q[$];
  int wb_q[$];
  int clr_cnt;
  logic prev_nz;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_nz = 1'b0;
    end else begin
      check("mac_en_lag", 32'(dp.mac_en), 32'(prev_nz));
      prev_nz = dp.nz_rd;
      if (dp.mac_clr) clr_cnt++;
      if (dp.nz_rd) begin
        check("nz_expected", 32'(nz_q.size() > 0), 1);
        if (nz_q.size() > 0) check("nz_addr", 32'(dp.nz_addr), nz_q.pop_front());
      end
      if (dp.wb_en) begin
        check("mac_wb_overlap", 32'(dp.mac_en), 0);
        check("wb_expected", 32'(wb_q.size() > 0), 1);
        if (wb_q.size() > 0) check("wb_row", 32'(dp.wb_row), wb_q.pop_front());
      end
    end
  end

  // Reference walk: returns busy-cycle count, mac_clr pulses and error flag.
  task automatic model(input int p[4], output int cyc, output int clr, output bit er);
    int lo, hi;
    cyc = 0; clr = 0; er = 1'b0;
    nz_q.delete();
    wb_q.delete();
    for (int r = 0; r < int'(N_ROWS); r++) begin
      clr++;
      lo = p[r];
      hi = p[r+1];
      cyc += 3;
      if (hi < lo || hi > int'(NNZ_MAX)) begin
        er = 1'b1;
        break;
      end
      for (int a = lo; a < hi; a++) nz_q.push_back(a);
      if (hi > lo) cyc += (hi - lo) + 1;
      cyc += 1;
      wb_q.push_back(r);
    end
    cyc += 1;
  endtask

  task automatic load(input int p[4]);
    for (int i = 0; i < 4; i++) rowptr[i] = NZ_W'(p[i]);
  endtask

  task automatic run_matrix(input int p0, input int p1, input int p2, input int p3,
                            input int restart_at, input bit start_in_done);
    int p[4];
    int exp_cyc, exp_clr, cnt;
    bit er, got;
    p = '{p0, p1, p2, p3};
    load(p);
    model(p, exp_cyc, exp_clr, er);
    clr_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (busy) cnt++;
      if (done) got = 1'b1;
      else begin
        start = (i == restart_at);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got), 1);
    check("run_cycles", cnt, exp_cyc);
    check("err_at_done", 32'(err), 32'(er));
    if (start_in_done) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("idle_busy", 32'(busy), 0);
    check("done_once", 32'(done), 0);
    check("err_sticky", 32'(err), 32'(er));
    check("perf_cycles", 32'(perf), PERF_ON ? exp_cyc : 0);
    check("nz_left", nz_q.size(), 0);
    check("wb_left", wb_q.size(), 0);
    check("clr_pulses", clr_cnt, exp_clr);
  endtask

  task automatic reset_mid_run();
    int p[4];
    int exp_cyc, exp_clr;
    bit er;
    p = '{0, 2, 4, 5};
    load(p);
    model(p, exp_cyc, exp_clr, er);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_stream", 32'(dp.nz_rd), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_wb_en", 32'(dp.wb_en), 0);
    check("rst_nz_rd", 32'(dp.nz_rd), 0);
    check("rst_nz_addr", 32'(dp.nz_addr), 0);
    nz_q.delete();
    wb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("idle_after_rst", 32'(busy), 0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) rowptr[i] = '0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy0", 32'(busy), 0);
    check("rst_done0", 32'(done), 0);
    check("rst_err0", 32'(err), 0);
    check("rst_perf0", 32'(perf), 0);
    check("rst_rp_addr0", 32'(dp.rp_addr), 0);
    check("rst_nz_addr0", 32'(dp.nz_addr), 0);
    check("rst_ctl0", 32'({dp.nz_rd, dp.mac_clr, dp.mac_en, dp.wb_en}), 0);
    check("rst_wb_row0", 32'(dp.wb_row), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_matrix(0, 2, 2, 5, -1, 1'b0);
    run_matrix(0, 2, 2, 5, 4, 1'b1);
    run_matrix(0, 3, 1, 4, -1, 1'b0);
    run_matrix(0, 2, 2, 5, -1, 1'b0);
    run_matrix(0, 0, 0, 0, -1, 1'b0);
    run_matrix(0, 9, 9, 9, -1, 1'b0);
    run_matrix(0, 10, 10, 10, -1, 1'b0);
    reset_mid_run();
    run_matrix(1, 3, 6, 7, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
